// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin sfifo write arbiter.
// FSM state encoding plus a clog2 width helper that never returns zero.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin search starting one past last_owner.
// Rotates the request vector so the first set bit is the winner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  parameter int C_ID_W    = clog2w(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [C_ID_W-1:0]    last_owner,
  output logic [C_ID_W-1:0]    winner,
  output logic                 any_valid
);

  logic [2*C_NUM_REQ-1:0] rot;
  int                     sum;

  always_comb begin
    rot       = {req, req} >> (int'(last_owner) + 1);
    winner    = '0;
    any_valid = 1'b0;
    sum       = 0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!any_valid && rot[i]) begin
        sum = int'(last_owner) + 1 + i;
        if (sum >= C_NUM_REQ) sum = sum - C_NUM_REQ;
        winner    = C_ID_W'(sum);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin N:1 burst arbiter feeding an sfifo write port.
// Define FIFO_WR_ARB_WATCHDOG_EN to add the stall watchdog and timeout.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int C_NUM_REQ    = 4,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_MAX_BURST  = 256,
  parameter int C_TIMEOUT    = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_NUM_REQ-1:0]              req_valid,
  input  logic [C_NUM_REQ-1:0]              req_last,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
  output logic [C_NUM_REQ-1:0]              req_ready,
  output logic [C_DATA_WIDTH-1:0]           fifo_wdata,
  output logic                              fifo_wren,
  input  logic                              fifo_wfull,
  output logic [clog2w(C_NUM_REQ)-1:0]      grant_id,
  output logic                              busy
`ifdef FIFO_WR_ARB_WATCHDOG_EN
  ,
  output logic                              timeout
`endif
);

  localparam int ID_W  = clog2w(C_NUM_REQ);
  localparam int CNT_W = clog2w(C_MAX_BURST + 1);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last_owner;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [CNT_W-1:0]  cnt;
  logic              sel_valid;
  logic              sel_last;
  logic              accept;
  logic              done;

  rr_pick #(
    .C_NUM_REQ (C_NUM_REQ),
    .C_ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    fifo_wdata = '0;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        fifo_wdata = req_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_valid  = req_valid[i];
        sel_last   = req_last[i];
      end
    end
  end

`ifdef FIFO_WR_ARB_WATCHDOG_EN
  localparam int TO_W = clog2w(C_TIMEOUT + 1);

  logic [TO_W-1:0] stall;
  logic            stall_hit;

  assign stall_hit = (state == BURST) && (stall == TO_W'(C_TIMEOUT));
  assign timeout   = stall_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= '0;
    end else if (state != BURST || accept || done) begin
      stall <= '0;
    end else if (!sel_valid) begin
      stall <= stall + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fifo_wren = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) state_nxt = BURST;
      end
      BURST: begin
        if (!fifo_wfull) req_ready = C_NUM_REQ'(1) << grant_id;
        fifo_wren = sel_valid & ~fifo_wfull;
        accept    = fifo_wren;
        // the beat that fills the burst to C_MAX_BURST also ends it
        done = accept &
               (sel_last | (cnt == CNT_W'(C_MAX_BURST - 1)));
`ifdef FIFO_WR_ARB_WATCHDOG_EN
        if (stall_hit) done = 1'b1;
`endif
        if (done) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= ID_W'(C_NUM_REQ - 1);
      grant_id   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) grant_id <= winner;
      if (accept) cnt <= cnt + 1'b1;
      if (done) begin
        last_owner <= grant_id;
        cnt        <= '0;
      end
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: per-requester beat queues drive
// the inputs, a negedge monitor pops expected beats and compares.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int MB = 256;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [N*D-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [D-1:0] fifo_wdata;
  logic         fifo_wren;
  logic         fifo_wfull;
  logic [1:0]   grant_id;
  logic         busy;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
  logic         timeout;
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .C_NUM_REQ    (N),
    .C_DATA_WIDTH (D),
    .C_MAX_BURST  (MB),
    .C_TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_wren  (fifo_wren),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_WATCHDOG_EN
    ,
    .timeout    (timeout)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          to_pulses = 0;
  logic [16:0] q[N][$];
  logic [15:0] exp_q[$];
  int          log_cyc[$];
  int          seqn[N];
  logic [N-1:0] acc = '0;
  logic [15:0] e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic apply();
    logic [16:0] h;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        h = q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[16];
        req_data[i*D +: D] = h[15:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*D +: D] = '0;
      end
    end
  endtask

  task automatic load(input int id, input int n, input int blen,
                      input bit end_last);
    logic [15:0] d;
    logic        l;
    for (int k = 0; k < n; k++) begin
      d = {4'(id), 12'(seqn[id])};
      l = ((k % blen) == blen - 1) || (end_last && k == n - 1);
      q[id].push_back({l, d});
      seqn[id]++;
    end
  endtask

  task automatic expect_beats(input int id, input int s0, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({4'(id), 12'(s0 + k)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #3;
      if (all_empty() && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL drain: timed out, %0d beats pending", exp_q.size());
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (log_cyc.size() >= n) return;
      @(negedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_log: got %0d beats needed %0d", log_cyc.size(), n);
  endtask

  // requester side: retire accepted heads, present the next ones
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    apply();
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc = '0;
    end else begin
      acc = req_valid & req_ready;
      if (fifo_wfull) begin
        chk("stall_wren", fifo_wren, 0);
        chk("stall_ready", req_ready, 0);
      end
      if (fifo_wren) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected data %h", fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", fifo_wdata, e);
          chk("beat_owner", grant_id, e[13:12]);
        end
        log_cyc.push_back(cyc);
      end
    end
`ifdef FIFO_WR_ARB_WATCHDOG_EN
    if (timeout) to_pulses++;
`endif
  end

  int base;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_wfull = 1'b0;
    for (int i = 0; i < N; i++) seqn[i] = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wren", fifo_wren, 0);
    chk("rst_grant", grant_id, 0);

    // S1: 1010 -> owner 1 for 3 beats, then owner 3
    @(posedge clk);
    #2;
    load(1, 3, 3, 1);
    load(3, 1, 1, 1);
    expect_beats(1, 0, 3);
    expect_beats(3, 0, 1);
    apply();
    @(negedge clk);
    chk("s1_idle_busy", busy, 0);
    @(negedge clk);
    chk("s1_grant", grant_id, 1);
    chk("s1_busy", busy, 1);
    chk("s1_ready", req_ready, 4'b0010);
    wait_drain(50);

    // S2: all valid, 2-beat bursts -> 0,1,2,3,0 with one bubble
    base = log_cyc.size();
    @(posedge clk);
    #2;
    load(0, 4, 2, 1);
    load(1, 2, 2, 1);
    load(2, 2, 2, 1);
    load(3, 2, 2, 1);
    expect_beats(0, 0, 2);
    expect_beats(1, 3, 2);
    expect_beats(2, 0, 2);
    expect_beats(3, 1, 2);
    expect_beats(0, 2, 2);
    apply();
    wait_drain(100);
    chk("s2_beats", log_cyc.size() - base, 10);
    if (log_cyc.size() >= base + 10)
      for (int k = 0; k < 9; k++)
        chk("s2_gap", log_cyc[base+k+1] - log_cyc[base+k],
            (k % 2) ? 2 : 1);

    // S3: wfull for 5 cycles after beat 2 of owner 2
    base = log_cyc.size();
    @(posedge clk);
    #2;
    load(2, 6, 6, 1);
    expect_beats(2, 2, 6);
    apply();
    wait_log(base + 2, 20);
    @(posedge clk);
    #2 fifo_wfull = 1'b1;
    repeat (5) @(posedge clk);
    #2 fifo_wfull = 1'b0;
    wait_drain(50);
    chk("s3_beats", log_cyc.size() - base, 6);
    if (log_cyc.size() >= base + 3)
      chk("s3_gap", log_cyc[base+2] - log_cyc[base+1], 6);

    // S4: 300 beats, forced release after 256
    base = log_cyc.size();
    @(posedge clk);
    #2;
    load(3, 300, 1000, 1);
    expect_beats(3, 3, 300);
    apply();
    wait_drain(400);
    chk("s4_beats", log_cyc.size() - base, 300);
    if (log_cyc.size() >= base + 257) begin
      chk("s4_gap255", log_cyc[base+255] - log_cyc[base+254], 1);
      chk("s4_gap256", log_cyc[base+256] - log_cyc[base+255], 2);
    end

    // S5: reset on beat 2 of a burst
    base = log_cyc.size();
    @(posedge clk);
    #2;
    load(2, 4, 4, 1);
    expect_beats(2, 8, 4);
    apply();
    wait_log(base + 1, 20);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    q[2].delete();
    exp_q.delete();
    apply();
    @(negedge clk);
    chk("s5_busy", busy, 0);
    chk("s5_ready", req_ready, 0);
    chk("s5_wren", fifo_wren, 0);
    chk("s5_grant_rst", grant_id, 0);
    @(posedge clk);
    #2;
    load(0, 1, 1, 1);
    load(2, 1, 1, 1);
    expect_beats(0, 4, 1);
    expect_beats(2, 12, 1);
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("s5_grant", grant_id, 0);
    chk("s5_busy2", busy, 1);
    wait_drain(50);

`ifdef FIFO_WR_ARB_WATCHDOG_EN
    // S6: owner 1 stalls, watchdog hands over to 2
    base = log_cyc.size();
    @(posedge clk);
    #2;
    load(1, 1, 100, 0);
    expect_beats(1, 5, 1);
    apply();
    wait_log(base + 1, 20);
    load(2, 1, 1, 1);
    expect_beats(2, 13, 1);
    apply();
    wait_drain(60);
    chk("s6_pulses", to_pulses, 1);
    if (log_cyc.size() >= base + 2)
      chk("s6_gap", log_cyc[base+1] - log_cyc[base], 11);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
